// File: rtl/param_proc_alu.sv
// Processor ALU: single-cycle arithmetic/logic/shift ops plus a WIDTH-cycle iterative signed multiply.
// Results and flags are registered; in_ready drops only while a multiply is iterating.
module param_proc_alu #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 7,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [IMM_W-1:0] immediate_offset,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_ORR  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_MOVI = 4'b0110;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_LSR  = 4'b1000;
    localparam logic [3:0] OP_LSL  = 4'b1001;
    localparam logic [3:0] OP_ROR  = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_ADR  = 4'b1100;
    localparam logic [3:0] OP_ADC  = 4'b1101;
    localparam logic [3:0] OP_SBC  = 4'b1110;
    localparam logic [3:0] OP_ASR  = 4'b1111;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t            state_q;
    logic [SH_W-1:0]   cnt_q;
    logic [WIDTH-1:0]  mcand_q, mplier_q, acc_q;
    logic              neg_q;
    logic [WIDTH-1:0]  result_q;
    logic              n_q, z_q, c_q, v_q;
    logic              out_valid_q;

    logic [WIDTH-1:0]  imm_ext;
    logic [SH_W-1:0]   sh;
    logic [SH_W:0]     rsh;
    logic [WIDTH-1:0]  b_op;
    logic              cin;
    logic [WIDTH:0]    sum;
    logic              sum_v;
    logic [WIDTH-1:0]  alu_res;
    logic              arith;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [WIDTH-1:0]  acc_d, prod_d;

    assign imm_ext = WIDTH'(immediate_offset);
    assign sh      = imm_ext[SH_W-1:0];
    assign rsh     = (SH_W+1)'(WIDTH) - {1'b0, sh};

    // Subtracts reuse the adder as A + ~B + cin, so carry-out is directly NOT borrow.
    always_comb begin
        b_op = operand_2;
        cin  = 1'b0;
        case (opcode)
            OP_SUB, OP_CMP: begin b_op = ~operand_2; cin = 1'b1; end
            OP_ADC:         cin = c_q;
            OP_SBC:         begin b_op = ~operand_2; cin = c_q; end
            default:        ;
        endcase
        sum   = {1'b0, operand_1} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
        sum_v = (operand_1[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != operand_1[WIDTH-1]);
    end

    always_comb begin
        alu_res = sum[WIDTH-1:0];
        arith   = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: arith = 1'b1;
            OP_CMP:  begin alu_res = '0; arith = 1'b1; end
            OP_ORR:  alu_res = operand_1 | operand_2;
            OP_AND:  alu_res = operand_1 & operand_2;
            OP_XOR:  alu_res = operand_1 ^ operand_2;
            OP_MOVI, OP_ADR: alu_res = imm_ext;
            OP_MOV:  alu_res = operand_1;
            OP_LSR:  alu_res = operand_1 >> sh;
            OP_LSL:  alu_res = operand_1 << sh;
            OP_ROR:  alu_res = (operand_1 >> sh) | (operand_1 << rsh);
            OP_ASR:  alu_res = WIDTH'($signed(operand_1) >>> sh);
            default: alu_res = '0;
        endcase
    end

    assign mag_a  = operand_1[WIDTH-1] ? (~operand_1 + 1'b1) : operand_1;
    assign mag_b  = operand_2[WIDTH-1] ? (~operand_2 + 1'b1) : operand_2;
    assign acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign prod_d = neg_q ? (~acc_d + 1'b1) : acc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (opcode == OP_MUL) begin
                            state_q  <= S_MUL;
                            cnt_q    <= '0;
                            mcand_q  <= mag_a;
                            mplier_q <= mag_b;
                            acc_q    <= '0;
                            neg_q    <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
                        end else begin
                            result_q    <= alu_res;
                            out_valid_q <= 1'b1;
                            if (arith) begin
                                n_q <= sum[WIDTH-1];
                                z_q <= (sum[WIDTH-1:0] == '0);
                                c_q <= sum[WIDTH];
                                v_q <= sum_v;
                            end
                        end
                    end
                end
                S_MUL: begin
                    // Only the low WIDTH product bits are kept, so dropping mcand MSBs is harmless.
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    acc_q    <= acc_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == SH_W'(WIDTH - 1)) begin
                        state_q     <= S_IDLE;
                        result_q    <= prod_d;
                        n_q         <= prod_d[WIDTH-1];
                        z_q         <= (prod_d == '0);
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign negative  = n_q;
    assign zero      = z_q;
    assign carry     = c_q;
    assign overflow  = v_q;

endmodule
